// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: shares one single-port, variable-latency memory between
// instruction fetch and load/store, one transaction in flight at a time.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr                 fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata      fetch accept pulse, completion, data
//   d_req/d_we/d_addr/d_wdata/d_be data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata         data accept pulse, completion, data
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be               registered memory request, held to ack
//   mem_ack/mem_rdata              memory completion and read data
//
// Data has priority. Fetch still wins once STREAK_MAX data grants have
// gone by back to back while fetch was waiting.
module mem_arbiter #(
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

    logic        state_q,     state_d;
    logic        owner_q,     owner_d;
    logic [3:0]  streak_q,    streak_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q,    mem_be_d;
    logic        if_gnt_q,    if_gnt_d;
    logic        d_gnt_q,     d_gnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        d_rvalid_q,  d_rvalid_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] d_rdata_q,   d_rdata_d;

    logic fetch_win;

    // Fetch only beats a pending data request once the streak is used up.
    assign fetch_win = if_req && (!d_req || (streak_q == STREAK_LIM));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = 32'd0;
        d_rdata_d   = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    state_d   = ST_BUSY;
                    mem_req_d = 1'b1;
                    if (fetch_win) begin
                        owner_d     = OWN_FETCH;
                        if_gnt_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = 32'd0;
                        mem_be_d    = 4'hF;
                        streak_d    = 4'd0;
                    end else begin
                        owner_d     = OWN_DATA;
                        d_gnt_d     = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_be;
                        // Streak only grows while fetch is actually waiting.
                        if (!if_req) begin
                            streak_d = 4'd0;
                        end else if (streak_q >= STREAK_LIM) begin
                            streak_d = STREAK_LIM;
                        end else begin
                            streak_d = streak_q + 4'd1;
                        end
                    end
                end
            end
            ST_BUSY: begin
                // BUSY is exactly the mem_req=1 window, so ack is honoured here only.
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_DATA) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_we_q ? 32'd0 : mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_FETCH;
            streak_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
// Expected transactions are queued in predicted grant order.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.STREAK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dreq_t;

    exp_t        sb[$];
    logic [31:0] fq[$];
    dreq_t       dq[$];

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   wait_n = 0;
    int   mcnt = 0;
    logic stray = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk) cyc++;

    // Memory: acks after wait_n wait cycles; stray drives ack in idle.
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (mcnt == wait_n) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_fn(mem_addr);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'd0;
                mcnt++;
            end
        end else begin
            mcnt      = 0;
            mem_ack   = stray;
            mem_rdata = 32'hBAD0_BAD0;
        end
    end

    // Requesters: present the next queued request, drop it after gnt.
    always @(negedge clk) begin
        if (if_gnt) begin
            if_req = 1'b0;
            void'(fq.pop_front());
        end else if (!if_req && fq.size() > 0) begin
            if_addr = fq[0];
            if_req  = 1'b1;
        end
        if (d_gnt) begin
            d_req = 1'b0;
            void'(dq.pop_front());
        end else if (!d_req && dq.size() > 0) begin
            d_we    = dq[0].we;
            d_addr  = dq[0].addr;
            d_wdata = dq[0].wdata;
            d_be    = dq[0].be;
            d_req   = 1'b1;
        end
    end

    // Monitor: grant owner, held payload, completion data and latency.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_gnt || d_gnt) begin
                check("gnt_onehot", {31'd0, if_gnt && d_gnt}, 32'd0);
                if (sb.size() == 0) begin
                    check("gnt_unexpected", 32'd1, 32'd0);
                end else begin
                    check("gnt_owner", {31'd0, d_gnt}, {31'd0, sb[0].is_d});
                    gnt_cyc = cyc;
                end
            end
            if (mem_req && sb.size() > 0) begin
                check("mem_addr", mem_addr, sb[0].addr);
                check("mem_we", {31'd0, mem_we}, {31'd0, sb[0].we});
                check("mem_wdata", mem_wdata, sb[0].wdata);
                check("mem_be", {28'd0, mem_be}, {28'd0, sb[0].be});
            end
            if (if_rvalid || d_rvalid) begin
                if (sb.size() == 0) begin
                    check("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rv_owner", {31'd0, d_rvalid}, {31'd0, e.is_d});
                    check("rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
                    check("other_rdata", e.is_d ? if_rdata : d_rdata, 32'd0);
                    check("other_rvalid",
                          {31'd0, e.is_d ? if_rvalid : d_rvalid}, 32'd0);
                    check("latency", cyc - gnt_cyc, wait_n + 1);
                end
            end
        end
    end

    task automatic req_f(input logic [31:0] a);
        fq.push_back(a);
    endtask

    task automatic req_d(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        dreq_t r;
        r.we = we; r.addr = a; r.wdata = wd; r.be = be;
        dq.push_back(r);
    endtask

    task automatic ex_f(input logic [31:0] a);
        exp_t e;
        e.is_d = 1'b0; e.we = 1'b0; e.addr = a;
        e.wdata = 32'd0; e.be = 4'hF; e.rdata = mem_fn(a);
        sb.push_back(e);
    endtask

    task automatic ex_d(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        e.is_d = 1'b1; e.we = we; e.addr = a;
        e.wdata = wd; e.be = be; e.rdata = we ? 32'd0 : mem_fn(a);
        sb.push_back(e);
    endtask

    task automatic dat(input int i, output logic we, output logic [31:0] a,
                       output logic [31:0] wd, output logic [3:0] be);
        we = (i % 2) == 1;
        a  = 32'h4000 + 32'(i * 4);
        wd = 32'h1000_0000 + 32'(i);
        be = we ? 4'b1100 : 4'hF;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && fq.size() == 0 && dq.size() == 0 &&
                !if_req && !d_req && !mem_req)
                done = 1'b1;
        end
        if (!done) begin
            check("timeout", 32'd0, 32'd1);
            sb.delete(); fq.delete(); dq.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
        check({tag, "_gnts"}, {30'd0, if_gnt, d_gnt}, 32'd0);
        check({tag, "_rvalids"}, {30'd0, if_rvalid, d_rvalid}, 32'd0);
        check({tag, "_if_rdata"}, if_rdata, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        logic        we;
        logic [31:0] a, wd;
        logic [3:0]  be;
        bit          seen;

        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0;
        d_wdata = 32'd0; d_be = 4'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single fetch, zero wait.
        @(posedge clk); #2;
        wait_n = 0;
        ex_f(32'h100); req_f(32'h100);
        wait_done();

        // Store with 3 wait cycles.
        @(posedge clk); #2;
        wait_n = 3;
        ex_d(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011);
        req_d(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011);
        wait_done();

        // Load with 2 wait cycles.
        @(posedge clk); #2;
        wait_n = 2;
        ex_d(1'b0, 32'h2008, 32'd0, 4'hF);
        req_d(1'b0, 32'h2008, 32'd0, 4'hF);
        wait_done();

        // Contention, zero wait: 4 data, fetch, 4 data, fetch, 2 data.
        @(posedge clk); #2;
        wait_n = 0;
        for (int i = 0; i < 10; i++) begin
            dat(i, we, a, wd, be);
            req_d(we, a, wd, be);
        end
        req_f(32'h200); req_f(32'h204);
        for (int i = 0; i < 4; i++) begin
            dat(i, we, a, wd, be); ex_d(we, a, wd, be);
        end
        ex_f(32'h200);
        for (int i = 4; i < 8; i++) begin
            dat(i, we, a, wd, be); ex_d(we, a, wd, be);
        end
        ex_f(32'h204);
        for (int i = 8; i < 10; i++) begin
            dat(i, we, a, wd, be); ex_d(we, a, wd, be);
        end
        wait_done();

        // Lone data grant, then contention: 4 data before the fetch.
        @(posedge clk); #2;
        wait_n = 1;
        dat(20, we, a, wd, be);
        ex_d(we, a, wd, be); req_d(we, a, wd, be);
        for (int i = 21; i < 25; i++) begin
            dat(i, we, a, wd, be); ex_d(we, a, wd, be);
        end
        ex_f(32'h300);
        dat(25, we, a, wd, be); ex_d(we, a, wd, be);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #2;
            if (dq.size() == 0) seen = 1'b1;
        end
        check("lone_gnt_seen", {31'd0, seen}, 32'd1);
        req_f(32'h300);
        for (int i = 21; i < 26; i++) begin
            dat(i, we, a, wd, be); req_d(we, a, wd, be);
        end
        wait_done();

        // Reset in the middle of a long transaction.
        @(posedge clk); #2;
        wait_n = 6;
        ex_d(1'b0, 32'h3000, 32'd0, 4'hF);
        req_d(1'b0, 32'h3000, 32'd0, 4'hF);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (d_gnt) seen = 1'b1;
        end
        check("rst_gnt_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        sb.delete();

        // Ack with no request outstanding must be ignored.
        stray = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stray_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
            check("stray_mem_req", {31'd0, mem_req}, 32'd0);
        end
        stray = 1'b0;
        @(negedge clk);

        // Still arbitrates normally afterwards.
        @(posedge clk); #2;
        wait_n = 0;
        ex_f(32'h400); req_f(32'h400);
        wait_done();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
